uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
// Memory-mapped UART transmitter, downstream of the CSR decode stage. Bytes written to CSR
// UARTFifoCsrAddr ('h50) are queued in a 32-entry FIFO. An 8N1 serializer drains the FIFO
// at CoreFreq/UartBaudRate. Status is readable at the same CSR address.
// An end-of-transmission interrupt pulse feeds the N-CLIC.
// PARAMETERS
// CsrAddr    config_pkg::UARTFifoCsrAddr ('h50)  CSR address for byte push and status read
// QueueSize  config_pkg::UARTFifoQueueSize (32)  FIFO depth in bytes; must be a power of 2
// CmpVal     config_pkg::UartCmpVal (173)        clock cycles per UART bit; must be >= 2
// PORTS
// clk         in   1   core clock
// reset       in   1   asynchronous, active-high reset
// csr_enable  in   1   CSR access strobe, valid for one cycle
// csr_addr    in   12  CSR address (CsrAddrT)
// csr_write   in   1   1 = write (push csr_wdata[7:0]), 0 = read
// csr_wdata   in   32  write data; only bits [7:0] are used
// csr_rdata   out  32  status, combinational when csr_addr==CsrAddr, else 0
// tx          out  1   serial line, registered, idles high
// busy        out  1   serializer not in IDLE
// tx_done     out  1   one-cycle pulse: last stop bit ended and FIFO is empty
// BEHAVIOUR
// - Reset: tx=1, busy=0, tx_done=0, FIFO empty, count=0, overflow=0, FSM=IDLE, baud counter=0.
//   Reset aborts any frame in flight. tx returns high immediately (async) and queued bytes are discarded.
// - FIFO: rd/wr pointers are clog2(QueueSize)+1 bits wide; the MSB is the wrap bit.
//   empty = pointers equal; full = low bits equal and MSBs differ; count is 0..QueueSize.
// - Push when csr_enable & csr_write & csr_addr==CsrAddr.
//   - Not full: store and increment the wr pointer.
//   - Full: drop the byte and set sticky overflow (cleared only by reset).
//   - Full is evaluated on the pre-pop state. A push in the same cycle as a pop at full is dropped.
//   - Push and pop in the same cycle while not full: both occur and count is unchanged.
// - csr_rdata: [5:0] count, [8] empty, [9] full, [10] busy, [11] overflow, all other bits 0.
//   Reads have no side effects.
// - FSM states: IDLE, START, DATA, STOP. The baud counter runs 0..CmpVal-1; the bit ends at CmpVal-1.
//   - IDLE: if !empty, pop the head into the shift register and go to START. tx falls on the next edge.
//     Write at edge N: FIFO non-empty after N; pop at N+1; tx=0 from N+2.
//   - START: tx=0 for CmpVal cycles, then DATA with bit index 0.
//   - DATA: tx=shift[0] (LSB first) for CmpVal cycles per bit. Shift right each bit.
//     After bit index 7, go to STOP.
//   - STOP: tx=1 for CmpVal cycles. At the end:
//     - FIFO non-empty: pop and go directly to START (no idle gap).
//     - FIFO empty: go to IDLE and pulse tx_done for exactly that cycle.
// - Frame = 10*CmpVal cycles exactly. No parity, one stop bit. busy=1 in START/DATA/STOP.
// - Bytes are transmitted in write order. Overflowed bytes never appear on tx.
// TESTING (benches override CmpVal=4)
// 1 Reset, then read status -> tx=1, csr_rdata=32'h0000_0100, busy=0, tx_done=0.
// 2 Write 8'h55 while idle -> tx low 2 cycles after the write edge.
//   Then 0,1,0,1,0,1,0,1,0,1 with 4 cycles per level (40 cycles); one tx_done at the end; busy=0 after.
// 3 Write 8'hA5 then 8'h3C on consecutive cycles -> 80 contiguous frame cycles, no idle gap.
//   Bits decode to A5 then 3C; exactly one tx_done.
// 4 Write 34 bytes 0..33 on consecutive cycles -> byte 0 popped, 1..32 queued, 33 dropped.
//   Status then shows full=1, count=32, overflow=1; 33 frames carry bytes 0..32.
// 5 Assert reset during DATA bit 3 of a frame with 5 bytes queued -> tx=1 at once.
//   Status=32'h100, no tx_done, and no further frames after reset release.
// 6 With the FIFO full, push in the same cycle as the STOP-end pop -> push dropped, overflow=1.
//   count goes 32->31; the next frame carries the byte queued earliest.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - CSR-fed 8N1 UART transmitter with a power-of-two byte FIFO
module uart_tx_fifo #(
    parameter logic [11:0] CsrAddr   = 12'h050,
    parameter int          QueueSize = 32,
    parameter int          CmpVal    = 173
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic        csr_write,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);
    localparam int AW = $clog2(QueueSize);
    localparam int BW = (CmpVal > 2) ? $clog2(CmpVal) : 1;
    localparam logic [BW-1:0] BaudLast = BW'(CmpVal - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [QueueSize];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic          empty, full, overflow;
    logic          push, do_push, pop, baud_end;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          unused_wdata;

    assign unused_wdata = ^csr_wdata[31:8];

    // Wrap bit in the pointer MSB distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count    = wr_ptr - rd_ptr;
    assign push     = csr_enable && csr_write && (csr_addr == CsrAddr);
    assign do_push  = push && !full;
    assign baud_end = (baud == BaudLast);
    assign pop      = !empty && ((state == IDLE) || (state == STOP && baud_end));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= csr_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && full) overflow <= 1'b1;
        end
    end

    // tx is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (!empty) begin
                        shift <= mem[rd_ptr[AW-1:0]];
                        state <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_end) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (!empty) begin
                            shift <= mem[rd_ptr[AW-1:0]];
                            state <= START;
                        end else begin
                            state   <= IDLE;
                            tx_done <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_addr == CsrAddr) begin
            csr_rdata[5:0] = 6'(count);
            csr_rdata[8]   = empty;
            csr_rdata[9]   = full;
            csr_rdata[10]  = busy;
            csr_rdata[11]  = overflow;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with CmpVal=4
module tb_uart_tx_fifo;
    localparam logic [11:0] CSR = 12'h050;
    localparam int CV = 4;
    localparam int FRAME = 10 * CV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_enable = 1'b0;
    logic [11:0] csr_addr = CSR;
    logic        csr_write = 1'b0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        tx, busy, tx_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int start_q[$];
    logic [7:0] rx_q[$];
    bit mon_active = 1'b0;
    int mon_cnt = 0;
    logic [7:0] mon_byte = '0;

    uart_tx_fifo #(.CsrAddr(CSR), .QueueSize(32), .CmpVal(CV)) dut (
        .clk(clk), .reset(rst), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .csr_write(csr_write), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    // Line receiver: samples each bit cell one cycle into it.
    always @(negedge clk) begin
        if (rst) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 4 && mon_cnt <= 32 && (mon_cnt % 4) == 0)
                mon_byte[3'((mon_cnt - 4) / 4)] <= tx;
            if (mon_cnt == 36) rx_q.push_back(mon_byte);
            if (mon_cnt == 38) mon_active <= 1'b0;
        end
    end

    function automatic logic frame_level(input logic [7:0] b, input int k);
        int slot;
        slot = k / CV;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic put(input logic [7:0] b, input logic [11:0] a);
        csr_enable = 1'b1;
        csr_write  = 1'b1;
        csr_addr   = a;
        csr_wdata  = {24'($urandom), b};
        @(negedge clk);
    endtask

    task automatic bus_idle();
        csr_enable = 1'b0;
        csr_write  = 1'b0;
        csr_addr   = CSR;
    endtask

    task automatic read_status(output logic [31:0] d);
        csr_enable = 1'b1;
        csr_write  = 1'b0;
        csr_addr   = CSR;
        #1;
        d = csr_rdata;
        csr_enable = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        bus_idle();
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic check_rx(input string name, input int r0, input logic [7:0] exp[$]);
        int errs;
        errs = 0;
        if (rx_q.size() - r0 != exp.size()) errs = 1000;
        else foreach (exp[i]) if (rx_q[r0 + i] !== exp[i]) errs++;
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL %s: got %0d bytes (%0d wrong), required %0d bytes", name,
                     rx_q.size() - r0, errs, exp.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_dut();
        read_status(d);
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
        tests++; if (d !== 32'h100) begin fails++; $display("FAIL reset_status: got %h want 00000100", d); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", tx_done); end
        csr_addr = 12'h051;
        #1;
        tests++; if (csr_rdata !== 32'h0) begin fails++; $display("FAIL other_addr_rdata: got %h want 0", csr_rdata); end
        bus_idle();
    endtask

    task automatic test_single_55();
        int n, s0, d0, errs;
        logic first;
        s0 = start_q.size();
        d0 = done_cnt;
        put(8'h55, CSR);
        bus_idle();
        n = cyc;
        @(negedge clk);
        first = tx;
        errs = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (tx !== frame_level(8'h55, k)) errs++;
        end
        tests++;
        if (first !== 1'b1 || start_q.size() <= s0 || start_q[s0] != n + 2) begin
            fails++;
            $display("FAIL latency_55: tx@N+1=%b start=%0d want tx=1 start=%0d", first,
                     (start_q.size() > s0) ? start_q[s0] : -1, n + 2);
        end
        tests++; if (errs != 0) begin fails++; $display("FAIL wave_55: %0d wrong cycles, want 0", errs); end
        wait_cycles(4);
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL done_55: got %0d pulses want 1", done_cnt - d0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_55: got %b want 0", busy); end
    endtask

    task automatic test_random(input int iter);
        logic [7:0] exp[$];
        logic [7:0] b;
        logic [31:0] d;
        int n, r0, d0;
        bit wrong;
        r0 = rx_q.size();
        d0 = done_cnt;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            wrong = (i > 0) && ($urandom_range(0, 3) == 0);
            put(b, wrong ? 12'h051 : CSR);
            if (!wrong) exp.push_back(b);
            bus_idle();
            wait_cycles($urandom_range(0, 3));
        end
        wait_cycles(FRAME * (n + 1));
        check_rx($sformatf("random_bytes_%0d", iter), r0, exp);
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL random_done_%0d: got %0d want 1", iter, done_cnt - d0); end
        read_status(d);
        tests++; if (d !== 32'h100) begin fails++; $display("FAIL random_status_%0d: got %h want 00000100", iter, d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        int s0, r0, d0, gap;
        s0 = start_q.size();
        r0 = rx_q.size();
        d0 = done_cnt;
        put(8'hA5, CSR);
        put(8'h3C, CSR);
        bus_idle();
        wait_cycles(2 * FRAME + 10);
        exp = '{8'hA5, 8'h3C};
        check_rx("b2b_bytes", r0, exp);
        gap = (start_q.size() >= s0 + 2) ? start_q[s0 + 1] - start_q[s0] : -1;
        tests++; if (gap != FRAME) begin fails++; $display("FAIL b2b_gap: got %0d want %0d", gap, FRAME); end
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL b2b_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_overflow_burst();
        logic [7:0] exp[$];
        logic [31:0] d;
        int r0, d0;
        r0 = rx_q.size();
        d0 = done_cnt;
        for (int i = 0; i < 34; i++) begin
            put(8'(i), CSR);
            if (i < 33) exp.push_back(8'(i));
        end
        bus_idle();
        read_status(d);
        tests++; if (d !== 32'hE20) begin fails++; $display("FAIL burst_status: got %h want 00000e20", d); end
        wait_cycles(33 * FRAME + 10);
        check_rx("burst_bytes", r0, exp);
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL burst_done: got %0d want 1", done_cnt - d0); end
        read_status(d);
        tests++; if (d !== 32'h900) begin fails++; $display("FAIL burst_end_status: got %h want 00000900", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int n, s1, d0;
        d0 = done_cnt;
        put(8'h00, CSR);
        n = cyc;
        for (int i = 0; i < 5; i++) put(8'($urandom), CSR);
        bus_idle();
        while (cyc < n + 19) @(negedge clk);
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL midframe_bit3: got %b want 0", tx); end
        #1 rst = 1'b1;
        #1;
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL async_reset_tx: got %b want 1", tx); end
        tests++; if (csr_rdata !== 32'h100) begin fails++; $display("FAIL async_reset_status: got %h want 00000100", csr_rdata); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        wait_cycles(3);
        rst = 1'b0;
        s1 = start_q.size();
        wait_cycles(3 * FRAME);
        tests++; if (start_q.size() != s1) begin fails++; $display("FAIL post_reset_frames: got %0d want 0", start_q.size() - s1); end
        tests++; if (done_cnt != d0) begin fails++; $display("FAIL post_reset_done: got %0d want 0", done_cnt - d0); end
        read_status(d);
        tests++; if (d !== 32'h100) begin fails++; $display("FAIL post_reset_status: got %h want 00000100", d); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp[$];
        logic [7:0] b;
        logic [31:0] d;
        int n0, r0;
        reset_dut();
        r0 = rx_q.size();
        b = 8'($urandom);
        put(b, CSR);
        exp.push_back(b);
        n0 = cyc;
        for (int i = 1; i < 33; i++) begin
            b = 8'($urandom);
            put(b, CSR);
            exp.push_back(b);
        end
        bus_idle();
        while (cyc < n0 + 40) @(negedge clk);
        read_status(d);
        tests++; if (d !== 32'h620) begin fails++; $display("FAIL full_before_pop: got %h want 00000620", d); end
        put(8'hEE, CSR);
        bus_idle();
        read_status(d);
        tests++; if (d !== 32'hC1F) begin fails++; $display("FAIL full_push_at_pop: got %h want 00000c1f", d); end
        wait_cycles(33 * FRAME + 10);
        check_rx("full_pop_bytes", r0, exp);
    endtask

    initial begin
        test_reset();
        test_single_55();
        for (int i = 0; i < 3; i++) test_random(i);
        test_back_to_back();
        test_overflow_burst();
        test_reset_midframe();
        test_full_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
